// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion ramp.
//   angle_t          : 8-bit servo angle
//   state_e          : ramp FSM encoding (ST_IDLE, ST_MOVE, ST_SETTLE)
//   NUM_SERVOS       : channel count (base, shoulder, elbow, gripper)
//   HOME_ANGLE_DEF   : default park angle after reset
//   clamp_angle()    : saturate an angle into [lo, hi]
package servo_pkg;

    typedef logic [7:0] angle_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int unsigned NUM_SERVOS     = 4;
    localparam int unsigned HOME_ANGLE_DEF = 128;

    function automatic angle_t clamp_angle(input angle_t a, input angle_t lo, input angle_t hi);
        angle_t r;
        r = a;
        if (a < lo) r = lo;
        if (a > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/servo_ramp_step.sv
// Combinational single-channel slew step.
// Ports:
//   angle_i     : current registered angle
//   target_i    : latched target angle
//   next_o      : angle after one ramp tick (moves at most STEP_SIZE, never overshoots)
//   at_target_o : current angle already equals target
module servo_ramp_step
    import servo_pkg::*;
#(
    parameter int unsigned STEP_SIZE = 2
) (
    input  angle_t angle_i,
    input  angle_t target_i,
    output angle_t next_o,
    output logic   at_target_o
);

    localparam logic [8:0] Step = 9'(STEP_SIZE);

    logic signed [8:0] diff;
    logic        [8:0] mag;

    always_comb begin
        // 9-bit signed difference covers the full -255..255 range
        diff        = $signed({1'b0, target_i}) - $signed({1'b0, angle_i});
        mag         = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        at_target_o = (diff == 9'sd0);
        if (mag <= Step) begin
            next_o = target_i;
        end else if (!diff[8]) begin
            next_o = angle_i + Step[7:0];
        end else begin
            next_o = angle_i - Step[7:0];
        end
    end

endmodule

// File: rtl/servo_motion_ramp.sv
// Slew-rate limiter between the gesture decoder and the 4-channel servo PWM driver.
// Accepts four target angles over valid/ready, then ramps each angle output toward
// its target by at most STEP_SIZE per ramp tick (CLK_FREQ/STEP_HZ cycles apart).
// Once all channels are on target and SETTLE_TICKS ticks have elapsed, done pulses.
// Optional feature: define SERVO_RAMP_LIMIT_EN to clamp accepted targets into
// [ANGLE_MIN, ANGLE_MAX]; otherwise targets are latched unmodified.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   cmd_valid_i       : target command valid
//   cmd_ready_o       : block can accept a command (IDLE and out of reset)
//   cmd_angle_[0-3]_i : target angles (base, shoulder, elbow, gripper)
//   angle_[0-3]_o     : registered ramped angles to the PWM driver
//   busy_o            : high in MOVE or SETTLE
//   done_o            : one-cycle pulse when a command completes
module servo_motion_ramp
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned STEP_HZ      = 1000,
    parameter int unsigned STEP_SIZE    = 2,
    parameter int unsigned SETTLE_TICKS = 50,
    parameter int unsigned HOME_ANGLE   = HOME_ANGLE_DEF,
    parameter int unsigned ANGLE_MIN    = 16,
    parameter int unsigned ANGLE_MAX    = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_angle_0_i,
    input  logic [7:0] cmd_angle_1_i,
    input  logic [7:0] cmd_angle_2_i,
    input  logic [7:0] cmd_angle_3_i,
    output logic [7:0] angle_0_o,
    output logic [7:0] angle_1_o,
    output logic [7:0] angle_2_o,
    output logic [7:0] angle_3_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned DIV     = CLK_FREQ / STEP_HZ;
    localparam int unsigned TickW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SettleW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

    localparam logic [TickW-1:0]   TickLast  = TickW'(DIV - 1);
    localparam logic [SettleW-1:0] SettleEnd = SettleW'(SETTLE_TICKS);
    localparam angle_t             Home      = angle_t'(HOME_ANGLE);
    localparam angle_t             LimLo     = angle_t'(ANGLE_MIN);
    localparam angle_t             LimHi     = angle_t'(ANGLE_MAX);

`ifdef SERVO_RAMP_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    state_e               state_q;
    logic [TickW-1:0]     tick_cnt_q;
    logic [SettleW-1:0]   settle_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    angle_t               angle_q  [NUM_SERVOS];
    angle_t               target_q [NUM_SERVOS];

    angle_t               cmd_ang  [NUM_SERVOS];
    angle_t               cmd_lat  [NUM_SERVOS];
    angle_t               next_ang [NUM_SERVOS];
    logic [NUM_SERVOS-1:0] at_tgt;
    logic                 all_at_tgt;
    logic                 tick;
    logic                 accept;
    logic [TickW-1:0]     tick_cnt_nxt;
    logic [SettleW-1:0]   settle_inc;

    assign cmd_ang[0] = cmd_angle_0_i;
    assign cmd_ang[1] = cmd_angle_1_i;
    assign cmd_ang[2] = cmd_angle_2_i;
    assign cmd_ang[3] = cmd_angle_3_i;

    always_comb begin
        for (int i = 0; i < NUM_SERVOS; i++) begin
            cmd_lat[i] = LimitEn ? clamp_angle(cmd_ang[i], LimLo, LimHi) : cmd_ang[i];
        end
    end

    for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_step
        servo_ramp_step #(
            .STEP_SIZE (STEP_SIZE)
        ) u_step (
            .angle_i     (angle_q[g]),
            .target_i    (target_q[g]),
            .next_o      (next_ang[g]),
            .at_target_o (at_tgt[g])
        );
    end

    assign cmd_ready_o  = (state_q == ST_IDLE) & rst_n;
    assign accept       = cmd_valid_i & cmd_ready_o;
    assign all_at_tgt   = &at_tgt;
    // Counter only advances outside IDLE, so gating on state keeps IDLE tick-free.
    assign tick         = (state_q != ST_IDLE) && (tick_cnt_q == TickLast);
    assign tick_cnt_nxt = tick ? '0 : tick_cnt_q + TickW'(1);
    assign settle_inc   = settle_cnt_q + SettleW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_SERVOS; i++) begin
                angle_q[i]  <= Home;
                target_q[i] <= Home;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        target_q   <= cmd_lat;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    tick_cnt_q <= tick_cnt_nxt;
                    // Arrival is judged on registered angles, so a zero-distance
                    // command leaves MOVE on its first cycle.
                    if (all_at_tgt) begin
                        settle_cnt_q <= '0;
                        if (SETTLE_TICKS == 0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end else if (tick) begin
                        angle_q <= next_ang;
                    end
                end
                ST_SETTLE: begin
                    tick_cnt_q <= tick_cnt_nxt;
                    if (tick) begin
                        settle_cnt_q <= settle_inc;
                        if (settle_inc == SettleEnd) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign angle_0_o = angle_q[0];
    assign angle_1_o = angle_q[1];
    assign angle_2_o = angle_q[2];
    assign angle_3_o = angle_q[3];
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_servo_motion_ramp.sv
// Scoreboard bench for servo_motion_ramp (DIV=10, STEP_SIZE=2, SETTLE_TICKS=2).
module tb_servo_motion_ramp;

    localparam int Div    = 10;
    localparam int Settle = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] c0 = 8'd0, c1 = 8'd0, c2 = 8'd0, c3 = 8'd0;
    logic [7:0] angle_0, angle_1, angle_2, angle_3;
    logic       busy, done;

    servo_motion_ramp #(
        .CLK_FREQ     (1000),
        .STEP_HZ      (100),
        .STEP_SIZE    (2),
        .SETTLE_TICKS (Settle),
        .HOME_ANGLE   (128),
        .ANGLE_MIN    (16),
        .ANGLE_MAX    (240)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_angle_0_i (c0),
        .cmd_angle_1_i (c1),
        .cmd_angle_2_i (c2),
        .cmd_angle_3_i (c3),
        .angle_0_o     (angle_0),
        .angle_1_o     (angle_1),
        .angle_2_o     (angle_2),
        .angle_3_o     (angle_3),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;  // index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ch;
        int         edge_n;
        logic [7:0] val;
    } step_t;

    typedef struct {
        int          edge_n;
        logic [31:0] angles;
    } done_t;

    step_t step_q[$];
    done_t done_exp[$];
    bit    mon_en = 1'b0;
    int    model [4];
    logic [7:0] prev [4];
    int    pend_done = 0;

    // Directed command table: targets and hand-computed tick count of the slowest channel.
    int cmd_tab  [4][4];
    int tick_tab [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampm(input int a);
`ifdef SERVO_RAMP_LIMIT_EN
        if (a < 16) return 16;
        if (a > 240) return 240;
`endif
        return a;
    endfunction

    // Push per-channel angle changes and the done event for a command accepted at edge acc.
    task automatic plan(input int acc, input int idx);
        int    tgt [4];
        int    m   [4];
        bit    moved;
        step_t s;
        done_t d;
        for (int ch = 0; ch < 4; ch++) begin
            tgt[ch] = clampm(cmd_tab[idx][ch]);
            m[ch]   = model[ch];
        end
        for (int k = 1; k <= 300; k++) begin
            moved = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                if (m[ch] != tgt[ch]) begin
                    if (m[ch] < tgt[ch]) m[ch] = (tgt[ch] - m[ch] <= 2) ? tgt[ch] : m[ch] + 2;
                    else                 m[ch] = (m[ch] - tgt[ch] <= 2) ? tgt[ch] : m[ch] - 2;
                    s.ch = ch; s.edge_n = acc + Div * k; s.val = 8'(m[ch]);
                    step_q.push_back(s);
                    moved = 1'b1;
                end
            end
            if (!moved) break;
        end
        d.edge_n = acc + Div * (tick_tab[idx] + Settle);
        d.angles = {8'(tgt[0]), 8'(tgt[1]), 8'(tgt[2]), 8'(tgt[3])};
        done_exp.push_back(d);
        pend_done = d.edge_n;
        for (int ch = 0; ch < 4; ch++) model[ch] = tgt[ch];
    endtask

    // Hold a command until accepted; cmd_ready must stay low until the previous done edge.
    task automatic send(input int idx);
        int acc;
        c0 = 8'(cmd_tab[idx][0]); c1 = 8'(cmd_tab[idx][1]);
        c2 = 8'(cmd_tab[idx][2]); c3 = 8'(cmd_tab[idx][3]);
        cmd_valid = 1'b1;
        for (int w = 0; w <= 3000; w++) begin
            if (w == 3000) begin
                checks++; errors++;
                $display("FAIL accept_timeout: cmd %0d never accepted, ready=%0d expected 1", idx, cmd_ready);
                break;
            end
            check("cmd_ready", int'(cmd_ready), int'(cyc >= pend_done));
            if (cmd_ready) break;
            @(negedge clk);
        end
        acc = cyc + 1;
        plan(acc, idx);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int w = 0; w <= 3000; w++) begin
            if (step_q.size() == 0 && done_exp.size() == 0) break;
            if (w == 3000) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d angle steps and %0d done pulses outstanding, expected 0",
                         step_q.size(), done_exp.size());
            end
            @(negedge clk);
        end
    endtask

    // Monitor: compares every angle change and every done pulse against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] cur [4];
        step_t      s;
        done_t      d;
        cur[0] = angle_0; cur[1] = angle_1; cur[2] = angle_2; cur[3] = angle_3;
        if (mon_en) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (cur[ch] !== prev[ch]) begin
                    if (step_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL angle_unexpected: ch%0d got %0d, expected %0d held", ch, cur[ch], prev[ch]);
                    end else begin
                        s = step_q.pop_front();
                        check("angle_channel", ch, s.ch);
                        check("angle_value", int'(cur[ch]), int'(s.val));
                        check("angle_edge", cyc, s.edge_n);
                    end
                end
            end
        end
        for (int ch = 0; ch < 4; ch++) prev[ch] = cur[ch];
        if (done === 1'b1) begin
            if (done_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: done=1 at edge %0d, expected 0", cyc);
            end else begin
                d = done_exp.pop_front();
                check("done_edge", cyc, d.edge_n);
                check("done_angles", int'({angle_0, angle_1, angle_2, angle_3}), int'(d.angles));
                check("done_busy", int'(busy), 0);
                check("done_ready", int'(cmd_ready), 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        cmd_tab[0] = '{138, 128, 128, 128}; tick_tab[0] = 5;
        cmd_tab[1] = '{129, 125, 128, 0};
        cmd_tab[2] = '{129, 125, 128, 0};   tick_tab[2] = 0;
        cmd_tab[3] = '{255, 0, 200, 100};
`ifdef SERVO_RAMP_LIMIT_EN
        tick_tab[1] = 56; tick_tab[3] = 56;
`else
        tick_tab[1] = 64; tick_tab[3] = 63;
`endif
        for (int ch = 0; ch < 4; ch++) model[ch] = 128;

        // Reset state
        repeat (3) @(negedge clk);
        check("ready_in_reset", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_angle0", int'(angle_0), 128);
        check("rst_angle1", int'(angle_1), 128);
        check("rst_angle2", int'(angle_2), 128);
        check("rst_angle3", int'(angle_3), 128);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Reset mid-move at angle_0 = 134: snap home, no done, command discarded
        c0 = 8'd140; c1 = 8'd128; c2 = 8'd128; c3 = 8'd128;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int w = 0; w < 200; w++) begin
            if (angle_0 == 8'd134) break;
            @(negedge clk);
        end
        check("midmove_angle0", int'(angle_0), 134);
        check("midmove_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_angle0", int'(angle_0), 128);
        check("midrst_angle1", int'(angle_1), 128);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(cmd_ready), 1);
        repeat (30) @(negedge clk);
        check("midrst_angle0_held", int'(angle_0), 128);
        check("midrst_idle_busy", int'(busy), 0);

        // Ramp up, then a backpressured command held during MOVE/SETTLE
        mon_en = 1'b1;
        send(0);
        send(1);
        cmd_valid = 1'b0;
        drain();

        // Zero-distance command
        send(2);
        cmd_valid = 1'b0;
        drain();

        // Extreme targets (clamped when the limit feature is built in)
        send(3);
        cmd_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_motion_ramp.md
Name: servo_motion_ramp

Overview:
Slew-rate limiter directly upstream of the 4-channel servo PWM driver. It accepts target angles for base, shoulder, elbow and gripper from the gesture decoder over a valid/ready handshake. It ramps the four 8-bit angle outputs toward their targets by a bounded step on each ramp tick, which protects servos and the mechanical arm from step jumps. A done pulse fires once every channel has reached its target and a settle time has elapsed.

Parameters:
CLK_FREQ, 100_000_000, clk frequency in Hz
STEP_HZ, 1000, ramp tick rate in Hz; DIV = CLK_FREQ/STEP_HZ, must be >= 2
STEP_SIZE, 2, maximum angle change per tick per channel (1..255)
SETTLE_TICKS, 50, ticks to hold at target before done; 0 means no settle
HOME_ANGLE, 128, angle and target value after reset
ANGLE_MIN, 16, lower clamp (optional feature only)
ANGLE_MAX, 240, upper clamp (optional feature only); ANGLE_MIN <= ANGLE_MAX

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  target command valid
cmd_ready  out  1  block can accept a command
cmd_angle_0..cmd_angle_3  in  8 each  target angles for base, shoulder, elbow, gripper
angle_0..angle_3  out  8 each  current ramped angles; feed the PWM driver
busy  out  1  high in MOVE or SETTLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset state: all registers clock-synchronous.
  - angle_* = HOME_ANGLE; internal targets = HOME_ANGLE; state = IDLE.
  - Tick counter = 0; settle counter = 0; done = 0; busy = 0.
- cmd_ready = (state == IDLE) & rst_n, combinational. It is 0 while reset is asserted.
- States: IDLE, MOVE, SETTLE.
- IDLE: a handshake (cmd_valid & cmd_ready) latches the four targets, sets the tick counter to 0 and moves to MOVE on the next cycle.
- MOVE, backpressure: cmd_valid is ignored (cmd_ready = 0). Upstream must hold the command.
- Tick generation: the tick counter runs only in MOVE and SETTLE. It counts 0..DIV-1 and wraps to 0. tick = 1 on the cycle the counter equals DIV-1.
  - The first tick therefore arrives exactly DIV cycles after the acceptance cycle.
- Per-channel step on tick in MOVE:
  - d = target - angle, computed as a 9-bit signed value.
  - If |d| <= STEP_SIZE: angle <= target.
  - Else: angle <= angle + STEP_SIZE if d > 0, or angle - STEP_SIZE if d < 0.
  - No overshoot is possible. No wrap past 0 or 255 is possible.
- Channels step independently. A channel already at target stays put.
- MOVE to SETTLE: on any cycle where all four angles equal their targets, evaluated on registered values.
  - The transition is also taken on the first MOVE cycle if the command equals the current angles (zero-distance command).
  - On entry, the settle counter = 0 and the tick counter keeps running.
- SETTLE: the settle counter increments on each tick. When it reaches SETTLE_TICKS, go to IDLE and assert done for that one transition cycle.
- SETTLE_TICKS = 0: MOVE goes directly to IDLE with done, skipping SETTLE.
- Angles are constant in SETTLE and IDLE.
- Reset mid-MOVE or mid-SETTLE: angles snap to HOME_ANGLE, no done pulse, and the in-flight command is discarded.
- Angle outputs are registered. The output update happens on the tick cycle edge.

Optional Feature:
Macro SERVO_RAMP_LIMIT_EN.
- Defined: each accepted cmd_angle is clamped to [ANGLE_MIN, ANGLE_MAX] before being latched as a target.
  - The reset HOME_ANGLE must lie inside the range.
- Undefined: targets are latched unmodified. ANGLE_MIN and ANGLE_MAX are unused.

Decomposition:
- Shared package servo_pkg:
  - angle_t (8-bit);
  - state encoding ST_IDLE, ST_MOVE, ST_SETTLE;
  - NUM_SERVOS = 4;
  - default HOME_ANGLE.
- One natural sub-module: servo_ramp_step. It is combinational: given angle, target and STEP_SIZE it returns the next angle and an at_target flag. Instantiate it four times.
- The tick divider and FSM stay in the top.

Test Plan:
(Bench parameters: CLK_FREQ=1000, STEP_HZ=100 so DIV=10, STEP_SIZE=2, SETTLE_TICKS=2.)
- Reset then release: angle_* = 128, cmd_ready = 1, busy = 0, done = 0.
- Command (138,128,128,128) accepted at cycle T:
  - angle_0 reads 130,132,...,138 after ticks at T+10, T+20, ..., T+50;
  - done pulses at T+70; cmd_ready returns high at T+70.
- Odd remainder and downward moves: from 128, command (129,125,128,0):
  - angle_0 = 129 after 1 tick; angle_1 = 126 then 125;
  - angle_3 reaches 0 after 64 ticks, with no underflow;
  - done comes after the slowest channel.
- Zero-distance command (128,128,128,128): no angle change; done exactly 2 ticks (20 cycles) after acceptance.
- Backpressure: cmd_valid held high with a new target during MOVE; cmd_ready = 0, and the command is accepted on the first IDLE cycle after done.
- Reset mid-move at angle_0 = 134: all angle_* = 128 the following cycle, no done, state IDLE. With SERVO_RAMP_LIMIT_EN, command (255,0,200,100) ramps toward (240,16,200,100).
